// File: rtl/sar_adc_if.sv
// Bus bundle for the successive-approximation ADC controller.
// The master side owns the trigger and the comparator. The slave side is the
// controller, which drives the DAC ladder, the result and the status lines.
interface sar_adc_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic             cmp_in;
    logic [WIDTH-1:0] dac;
    logic [WIDTH-1:0] sample;
    logic             sample_valid;
    logic             busy;

    modport master (
        output start,
        output cmp_in,
        input  dac,
        input  sample,
        input  sample_valid,
        input  busy
    );

    modport slave (
        input  start,
        input  cmp_in,
        output dac,
        output sample,
        output sample_valid,
        output busy
    );
endinterface

// File: rtl/sar_adc.sv
// Successive-approximation ADC controller.
// It drives a WIDTH-bit resistor-ladder DAC and binary-searches the external
// comparator from MSB to LSB. Each bit trial lasts SETTLE_CYCLES clocks.
// A finished conversion is published on sample, together with a one-cycle
// sample_valid strobe.
module sar_adc #(
    parameter int WIDTH         = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int AUTO          = 0,
    parameter int SAMPLE_PERIOD = 1250
) (
    input  logic   clk,
    input  logic   rst_n,
    sar_adc_if.slave adc
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CONVERT = 1'b1
    } state_t;

    // Returns a one-hot word with bit idx set.
    function automatic logic [WIDTH-1:0] bit_mask(input logic [BIT_W-1:0] idx);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Returns value with bit idx replaced by b. All other bits are left unchanged.
    function automatic logic [WIDTH-1:0] set_bit(input logic [WIDTH-1:0] value,
                                                 input logic [BIT_W-1:0] idx,
                                                 input logic             b);
        logic [WIDTH-1:0] v;
        v      = value;
        v[idx] = b;
        return v;
    endfunction

    logic             cmp_meta_r;
    logic             cmp_s;
    logic [PER_W-1:0] period_r;
    state_t           state_r;
    logic [BIT_W-1:0] bit_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] dac_r;
    logic [WIDTH-1:0] sample_r;
    logic             valid_r;
    logic             busy_r;

    logic             auto_hit_s;
    logic             trigger_s;
    logic             settled_s;
    logic [WIDTH-1:0] decided_s;
    logic [WIDTH-1:0] next_trial_s;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_meta_r <= 1'b0;
            cmp_s      <= 1'b0;
        end else begin
            cmp_meta_r <= adc.cmp_in;
            cmp_s      <= cmp_meta_r;
        end
    end

    // Free-running period counter. It paces the self-triggered conversions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_r <= {PER_W{1'b0}};
        end else if (auto_hit_s) begin
            period_r <= {PER_W{1'b0}};
        end else begin
            period_r <= period_r + PER_W'(1);
        end
    end

    // Trigger selection, bit decision and the next trial word for the ladder.
    always_comb begin
        auto_hit_s = (period_r == PER_W'(SAMPLE_PERIOD - 1));
        if (AUTO != 0) begin
            trigger_s = auto_hit_s;
        end else begin
            trigger_s = adc.start;
        end
        settled_s = (cnt_r == CNT_W'(SETTLE_CYCLES - 1));
        decided_s = set_bit(result_r, bit_r, cmp_s);
        if (bit_r != {BIT_W{1'b0}}) begin
            next_trial_s = decided_s | bit_mask(bit_r - BIT_W'(1));
        end else begin
            next_trial_s = decided_s;
        end
    end

    // Conversion FSM. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            bit_r    <= {BIT_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            result_r <= {WIDTH{1'b0}};
            dac_r    <= {WIDTH{1'b0}};
            sample_r <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (trigger_s) begin
                        result_r <= {WIDTH{1'b0}};
                        bit_r    <= BIT_W'(WIDTH - 1);
                        cnt_r    <= {CNT_W{1'b0}};
                        dac_r    <= bit_mask(BIT_W'(WIDTH - 1));
                        busy_r   <= 1'b1;
                        state_r  <= ST_CONVERT;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    if (settled_s) begin
                        result_r <= decided_s;
                        if (bit_r != {BIT_W{1'b0}}) begin
                            bit_r <= bit_r - BIT_W'(1);
                            cnt_r <= {CNT_W{1'b0}};
                            dac_r <= next_trial_s;
                        end else begin
                            sample_r <= decided_s;
                            dac_r    <= decided_s;
                            valid_r  <= 1'b1;
                            busy_r   <= 1'b0;
                            state_r  <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign adc.dac          = dac_r;
    assign adc.sample       = sample_r;
    assign adc.sample_valid = valid_r;
    assign adc.busy         = busy_r;

endmodule

// File: tb/tb_sar_adc.sv
// Self-checking bench for sar_adc.
// An ideal comparator compares a target code against the DAC output.
// The expected trials and results come from plain binary-search arithmetic on
// that target code.
module tb_sar_adc;

    localparam int W      = 10;
    localparam int S      = 4;
    localparam int CONV   = W * S;
    localparam int PERIOD = 1250;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rst1_n;
    logic [W-1:0] target0;
    logic [W-1:0] target1;
    int           checks = 0;
    int           errors = 0;

    always #40 clk = ~clk;

    sar_adc_if #(.WIDTH(W)) bus0 ();
    sar_adc_if #(.WIDTH(W)) bus1 ();

    assign bus0.cmp_in = (target0 >= bus0.dac);
    assign bus1.cmp_in = (target1 >= bus1.dac);

    sar_adc #(.WIDTH(W), .SETTLE_CYCLES(S), .AUTO(0), .SAMPLE_PERIOD(PERIOD)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .adc   (bus0.slave)
    );

    sar_adc #(.WIDTH(W), .SETTLE_CYCLES(S), .AUTO(1), .SAMPLE_PERIOD(PERIOD)) u_dut1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .adc   (bus1.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Trial word for bit i: the bits of code above i are kept, and bit i is set.
    function automatic logic [W-1:0] ref_trial(input logic [W-1:0] code, input int i);
        int keep;
        keep = (int'(code) >> (i + 1)) << (i + 1);
        return W'(keep | (1 << i));
    endfunction

    // One start-triggered conversion on dut0. Call this at a negedge.
    // When abort_at >= 0, reset is asserted at that clock of the conversion.
    task automatic run_conv(input logic [W-1:0] code, input int abort_at);
        int n;
        n = 0;
        while (bus0.busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_wait", 32'(n < 100), 32'd1);
        target0    = code;
        bus0.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < CONV; k++) begin
            if (k == abort_at) begin
                bus0.start = 1'b0;
                rst_n      = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_val("abort_dac", 32'(bus0.dac), 32'd0);
                check_val("abort_sample", 32'(bus0.sample), 32'd0);
                check_val("abort_valid", 32'(bus0.sample_valid), 32'd0);
                check_val("abort_busy", 32'(bus0.busy), 32'd0);
                rst_n = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    check_val("post_abort_valid", 32'(bus0.sample_valid), 32'd0);
                    check_val("post_abort_busy", 32'(bus0.busy), 32'd0);
                end
                return;
            end
            check_val("busy_conv", 32'(bus0.busy), 32'd1);
            check_val("valid_conv", 32'(bus0.sample_valid), 32'd0);
            if (k % S == 0) begin
                check_val("dac_trial", 32'(bus0.dac), 32'(ref_trial(code, W - 1 - k / S)));
            end
            // These pulses land on a mid-conversion edge and on the completion edge.
            bus0.start = (k == CONV / 2) || (k == CONV - 1);
            @(negedge clk);
        end
        check_val("valid_done", 32'(bus0.sample_valid), 32'd1);
        check_val("sample_done", 32'(bus0.sample), 32'(code));
        check_val("dac_done", 32'(bus0.dac), 32'(code));
        check_val("busy_done", 32'(bus0.busy), 32'd0);
        bus0.start = 1'b0;
        @(negedge clk);
        check_val("valid_one_cycle", 32'(bus0.sample_valid), 32'd0);
        check_val("no_restart", 32'(bus0.busy), 32'd0);
        check_val("sample_hold", 32'(bus0.sample), 32'(code));
    endtask

    initial begin
        int     vcyc[$];
        int     busy_low;
        int     cyc;
        int     nconv;
        logic   exp_v;

        rst_n      = 1'b0;
        rst1_n     = 1'b0;
        bus0.start = 1'b0;
        bus1.start = 1'b1;
        target0    = '0;
        target1    = '0;
        repeat (3) @(negedge clk);
        check_val("rst_dac", 32'(bus0.dac), 32'd0);
        check_val("rst_sample", 32'(bus0.sample), 32'd0);
        check_val("rst_valid", 32'(bus0.sample_valid), 32'd0);
        check_val("rst_busy", 32'(bus0.busy), 32'd0);
        check_val("rst_busy_auto", 32'(bus1.busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed and boundary targets, then randomized targets.
        run_conv(10'h2A5, -1);
        run_conv(10'h000, -1);
        run_conv(10'h3FF, -1);
        run_conv(10'h200, -1);
        for (int r = 0; r < 6; r++) begin
            run_conv(W'($urandom_range(0, 1023)), -1);
        end

        // Hold start high continuously. Conversions repeat every CONV+1 clocks.
        target0    = 10'h155;
        bus0.start = 1'b1;
        busy_low   = 0;
        cyc        = 0;
        while (vcyc.size() < 3 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (vcyc.size() > 0 && bus0.busy === 1'b0) busy_low++;
            if (bus0.sample_valid === 1'b1) begin
                vcyc.push_back(cyc);
                check_val("held_sample", 32'(bus0.sample), 32'h155);
                if (vcyc.size() == 1) busy_low = 1;
            end
        end
        bus0.start = 1'b0;
        check_val("held_count", 32'(vcyc.size()), 32'd3);
        if (vcyc.size() == 3) begin
            check_val("held_first_lat", 32'(vcyc[0]), 32'(CONV + 1));
            check_val("held_gap1", 32'(vcyc[1] - vcyc[0]), 32'(CONV + 1));
            check_val("held_gap2", 32'(vcyc[2] - vcyc[1]), 32'(CONV + 1));
        end
        check_val("held_busy_low", 32'(busy_low), 32'd3);

        // Abort at clock 20, then run a clean conversion.
        run_conv(10'h1C3, 20);
        run_conv(W'($urandom_range(0, 1023)), -1);

        // Self-triggered instance. The target ramps by one after each sample.
        target1 = W'($urandom_range(0, 1000));
        @(negedge clk);
        rst1_n = 1'b1;
        nconv  = 0;
        for (int e = 0; e < 3 * PERIOD + CONV + 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            exp_v = (e >= PERIOD - 1 + CONV) && ((e - (PERIOD - 1 + CONV)) % PERIOD == 0);
            if (e == PERIOD - 2) check_val("auto_pre_idle", 32'(bus1.busy), 32'd0);
            if ((e + 1) % PERIOD == 0) check_val("auto_trigger", 32'(bus1.busy), 32'd1);
            if (exp_v || bus1.sample_valid === 1'b1) begin
                check_val("auto_valid", 32'(bus1.sample_valid), 32'(exp_v));
                if (exp_v) begin
                    check_val("auto_sample", 32'(bus1.sample), 32'(target1));
                    nconv++;
                    target1 = target1 + W'(1);
                end
            end
        end
        check_val("auto_count", 32'(nconv), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sar_adc.md
# sar_adc

Successive-approximation ADC controller for the Project 3 board. It is the input-side counterpart of the sine generator. It drives the same style of 10-bit resistor-ladder DAC, reads an external analog comparator that compares the input signal against the ladder voltage, and binary-searches one bit per step from MSB to LSB. It delivers one digital sample per conversion, with a one-cycle valid strobe, to downstream logic such as a sample buffer or a display.

## Interface
- WIDTH, 10: DAC/sample resolution in bits.
- SETTLE_CYCLES, 4: clocks per bit trial (ladder settle plus comparator plus 2-flop sync). Must be ≥ 3.
- AUTO, 0: 1 = self-triggered conversions every SAMPLE_PERIOD clocks; 0 = start-triggered.
- SAMPLE_PERIOD, 1250: auto-trigger period in clocks (10 kHz at the 12.5 MHz board clock). Must be ≥ WIDTH*SETTLE_CYCLES+1.
- clk  input  1  system clock (12.5 MHz, 80 ns period).
- rst_n  input  1  reset; one clock, synchronous, active-low.
- start  input  1  conversion request, sampled in IDLE only (ignored when AUTO=1).
- cmp_in  input  1  async comparator output: 1 = analog input ≥ DAC voltage.
- dac  output  WIDTH  ladder drive, MSB = dac[WIDTH-1].
- sample  output  WIDTH  last completed conversion result.
- sample_valid  output  1  one-cycle strobe when sample updates.
- busy  output  1  conversion in progress.

## Operation
- cmp_in passes through a 2-flop synchronizer (cmp_s). Only cmp_s is used.
- States:
  - IDLE: busy=0, dac holds its last value.
  - CONVERT: busy=1; bit index i runs WIDTH-1 down to 0, with settle counter cnt from 0 to SETTLE_CYCLES-1.
- Trigger:
  - AUTO=0: start=1 in IDLE.
  - AUTO=1: a free-running period counter (0..SAMPLE_PERIOD-1, cleared by reset) reaches SAMPLE_PERIOD-1.
  - A trigger that occurs while busy is dropped; no queueing.
- On the trigger edge:
  - result ← 0, i ← WIDTH-1, cnt ← 0.
  - dac ← 1<<(WIDTH-1).
  - State → CONVERT.
- Decision edge, when cnt = SETTLE_CYCLES-1:
  - result[i] ← cmp_s; all other result bits unchanged.
  - If i>0: i ← i-1, cnt ← 0, dac ← (result with bit i set to cmp_s) | 1<<(i-1).
  - If i=0: sample ← final result, dac ← final result, sample_valid ← 1, state → IDLE.
- All other CONVERT edges: cnt ← cnt+1.
- Arithmetic is unsigned straight binary. A code of all-ones means the input is ≥ full-scale trial; no saturation logic is needed.
- Reset values: dac=0, sample=0, sample_valid=0, busy=0, state IDLE, synchronizer flops 0, period counter 0.
- Reset mid-conversion aborts immediately. No sample_valid is produced and the partial result is discarded.

## Timing
- Trigger at edge t produces:
  - first trial on dac after edge t;
  - MSB decision at edge t+SETTLE_CYCLES;
  - final decision at t+WIDTH*SETTLE_CYCLES.
- Conversion latency is therefore WIDTH*SETTLE_CYCLES clocks: 40 clocks (3.2 µs) at the defaults.
- busy is high from edge t through edge t+WIDTH*SETTLE_CYCLES-1. It falls at the edge where sample_valid rises.
- sample_valid is high for exactly the one cycle after the final decision edge. sample is stable from then until the next completion.
- start is ignored on any edge where busy=1, including the completion edge. The earliest restart is the following edge, so back-to-back conversions have a period of WIDTH*SETTLE_CYCLES+1 clocks.
- Comparator timing: the bit decided at a decision edge uses cmp_in as captured 2 edges earlier. With SETTLE_CYCLES ≥ 3, that capture is at least 1 clock after the trial is applied.
- AUTO=1 conversions start at edges SAMPLE_PERIOD-1, 2*SAMPLE_PERIOD-1, and so on, counted after reset release.

## Test plan
- Ideal comparator model: cmp_in = (code ≥ dac). With target 0x2A5 and one start pulse, sample=0x2A5 and sample_valid is high for exactly 1 cycle, 40 clocks after start. Trial sequence on dac begins 0x200, 0x300, 0x280, …
- Boundary codes: target 0x000 gives 0x000 with dac stepping 0x200, 0x100, …, 0x001. Target 0x3FF gives 0x3FF. Target 0x200 gives 0x200.
- start held high continuously with target 0x155: one conversion every 41 clocks, every sample=0x155, busy low exactly 1 cycle between conversions. A start pulse mid-conversion is ignored, with no latency change.
- rst_n low at clock 20 of a conversion: every output is 0 on the next edge, no sample_valid is produced, and a new start afterwards converts correctly.
- AUTO=1, SAMPLE_PERIOD=1250, target ramping +1 per conversion: sample_valid fires at reset-relative cycles 1249+40, 2499+40, …, and each sample equals the target applied at its trigger.
